// File: rtl/core_task_dispatcher.sv
// Shares slave cores 1..3 among tasks queued by core 0: an in-order FIFO feeds a
// two-state dispatcher that strobes the chosen slave and tracks it busy until its end pulse.
module core_task_dispatcher #(
  parameter int ADR_W = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [1:0]       req_core,
  output logic             req_ready,
  output logic             cpu1_start,
  output logic             cpu2_start,
  output logic             cpu3_start,
  output logic [ADR_W-1:0] cpu1_start_adr,
  output logic [ADR_W-1:0] cpu2_start_adr,
  output logic [ADR_W-1:0] cpu3_start_adr,
  input  logic             cpu1_end,
  input  logic             cpu2_end,
  input  logic             cpu3_end,
  output logic [2:0]       core_state,
  output logic [CW-1:0]    fifo_count,
  output logic             all_idle
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [1:0]       core;
    logic [ADR_W-1:0] adr;
  } entry_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  entry_t [DEPTH-1:0]    fifo_q, fifo_d;
  logic   [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic   [CW-1:0]       count_q, count_d;
  state_e                state_q, state_d;
  logic   [1:0]          last_q, last_d;
  logic   [2:0]          busy_q, busy_d, start_q, start_d;
  logic   [2:0][ADR_W-1:0] adr_q, adr_d;

  entry_t     head;
  logic       push, pop, sel_vld;
  logic [1:0] sel, cand;
  logic [2:0] end_v, issue_oh;

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == 2'd3) ? 2'd1 : s + 2'd1;
  endfunction

  assign head  = fifo_q[rd_ptr_q];
  assign end_v = {cpu3_end, cpu2_end, cpu1_end};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 2'd3;
      busy_q   <= '0;
      start_q  <= '0;
      adr_q    <= '0;
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      adr_q    <= adr_d;
    end
  end

  // Selection sees only registered busy bits, so an end in this cycle frees the slave next cycle.
  always_comb begin
    sel_vld = 1'b0;
    sel     = 2'd0;
    cand    = last_q;
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (head.core == 2'd0) begin
            for (int i = 0; i < 3; i++) begin
              cand = rr_next(cand);
              if (!sel_vld && !busy_q[cand - 2'd1]) begin
                sel_vld = 1'b1;
                sel     = cand;
              end
            end
          end else if (!busy_q[head.core - 2'd1]) begin
            sel_vld = 1'b1;
            sel     = head.core;
          end
        end
        if (sel_vld) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_oh = sel_vld ? (3'b001 << (sel - 2'd1)) : 3'b000;
    push     = req_valid && req_ready;
    pop      = sel_vld;
    fifo_d   = fifo_q;
    if (push) fifo_d[wr_ptr_q] = '{core: req_core, adr: req_adr};
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    last_d   = sel_vld ? sel : last_q;
    busy_d   = (busy_q & ~end_v) | issue_oh;
    start_d  = issue_oh;
    adr_d    = adr_q;
    for (int k = 0; k < 3; k++)
      if (issue_oh[k]) adr_d[k] = head.adr;
  end

  assign req_ready      = (count_q != CW'(DEPTH));
  assign all_idle       = (count_q == '0) && (busy_q == '0);
  assign core_state     = busy_q;
  assign fifo_count     = count_q;
  assign cpu1_start     = start_q[0];
  assign cpu2_start     = start_q[1];
  assign cpu3_start     = start_q[2];
  assign cpu1_start_adr = adr_q[0];
  assign cpu2_start_adr = adr_q[1];
  assign cpu3_start_adr = adr_q[2];

endmodule

// File: tb/tb_core_task_dispatcher.sv
// Directed bench for core_task_dispatcher: issue order, back-pressure, head-of-line
// blocking, end/select overlap and asynchronous reset.
module tb_core_task_dispatcher;
  localparam int ADR_W = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [ADR_W-1:0] req_adr;
  logic [1:0]       req_core;
  logic             req_ready;
  logic             cpu1_start, cpu2_start, cpu3_start;
  logic [ADR_W-1:0] cpu1_start_adr, cpu2_start_adr, cpu3_start_adr;
  logic             cpu1_end, cpu2_end, cpu3_end;
  logic [2:0]       core_state;
  logic [CW-1:0]    fifo_count;
  logic             all_idle;
  logic [2:0]       starts;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign starts = {cpu3_start, cpu2_start, cpu1_start};

  core_task_dispatcher #(.ADR_W(ADR_W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_adr(req_adr), .req_core(req_core), .req_ready(req_ready),
    .cpu1_start(cpu1_start), .cpu2_start(cpu2_start), .cpu3_start(cpu3_start),
    .cpu1_start_adr(cpu1_start_adr), .cpu2_start_adr(cpu2_start_adr), .cpu3_start_adr(cpu3_start_adr),
    .cpu1_end(cpu1_end), .cpu2_end(cpu2_end), .cpu3_end(cpu3_end),
    .core_state(core_state), .fifo_count(fifo_count), .all_idle(all_idle)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 1'b0; req_adr = '0; req_core = 2'd0;
    cpu1_end = 1'b0; cpu2_end = 1'b0; cpu3_end = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic push(input logic [ADR_W-1:0] adr, input logic [1:0] core);
    req_valid = 1'b1; req_adr = adr; req_core = core;
    step();
    req_valid = 1'b0;
  endtask

  task automatic pulse_end(input int k);
    cpu1_end = (k == 1); cpu2_end = (k == 2); cpu3_end = (k == 3);
    step();
    cpu1_end = 1'b0; cpu2_end = 1'b0; cpu3_end = 1'b0;
  endtask

  // Bounded wait for slave k's start strobe; returns with the strobe visible.
  task automatic wait_start(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (starts[k-1]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (all_idle !== 1'b1) begin errors++; $display("FAIL reset_all_idle: got %b want 1", all_idle); end
    checks++; if (core_state !== 3'b000) begin errors++; $display("FAIL reset_core_state: got %b want 000", core_state); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (starts !== 3'b000) begin errors++; $display("FAIL reset_starts: got %b want 000", starts); end
    checks++; if ({cpu1_start_adr, cpu2_start_adr, cpu3_start_adr} !== 48'h0) begin errors++; $display("FAIL reset_adrs: got %h want 0", {cpu1_start_adr, cpu2_start_adr, cpu3_start_adr}); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    push(16'h0100, 2'd0);
    wait_start(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_start: got timeout want cpu1_start"); end
    checks++; if (cpu1_start_adr !== 16'h0100) begin errors++; $display("FAIL single_adr: got %h want 0100", cpu1_start_adr); end
    checks++; if (core_state !== 3'b001) begin errors++; $display("FAIL single_busy: got %b want 001", core_state); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count: got %0d want 0", fifo_count); end
    checks++; if (all_idle !== 1'b0) begin errors++; $display("FAIL single_all_idle: got %b want 0", all_idle); end
    step();
    checks++; if (starts !== 3'b000) begin errors++; $display("FAIL single_strobe_width: got %b want 000", starts); end
    pulse_end(1);
    checks++; if (core_state !== 3'b000) begin errors++; $display("FAIL single_end: got %b want 000", core_state); end
  endtask

  task automatic test_back_to_back();
    int n;
    int who[8];
    int cyc[8];
    bit ok;
    do_reset();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid = (i < 4);
      req_adr   = ADR_W'((i + 1) * 16);
      req_core  = 2'd0;
      step();
      req_valid = 1'b0;
      if (starts != 3'b000 && n < 8) begin
        who[n] = (starts == 3'b001) ? 1 : (starts == 3'b010) ? 2 : (starts == 3'b100) ? 3 : 9;
        cyc[n] = i;
        n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_issue_count: got %0d want 3", n); end
    if (n == 3) begin
      checks++; if ({who[0], who[1], who[2]} !== {32'd1, 32'd2, 32'd3}) begin errors++; $display("FAIL b2b_order: got %0d %0d %0d want 1 2 3", who[0], who[1], who[2]); end
      checks++; if ((cyc[1] - cyc[0]) !== 2 || (cyc[2] - cyc[1]) !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d %0d want 2 2", cyc[1] - cyc[0], cyc[2] - cyc[1]); end
    end
    checks++; if ({cpu1_start_adr, cpu2_start_adr, cpu3_start_adr} !== {16'h10, 16'h20, 16'h30}) begin errors++; $display("FAIL b2b_adrs: got %h %h %h want 0010 0020 0030", cpu1_start_adr, cpu2_start_adr, cpu3_start_adr); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_queued: got %0d want 1", fifo_count); end
    checks++; if (core_state !== 3'b111) begin errors++; $display("FAIL b2b_busy: got %b want 111", core_state); end
    pulse_end(2);
    wait_start(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_fourth_start: got timeout want cpu2_start"); end
    checks++; if (cpu2_start_adr !== 16'h0040) begin errors++; $display("FAIL b2b_fourth_adr: got %h want 0040", cpu2_start_adr); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) push(ADR_W'(16'h0F00 + i), 2'd0);
    repeat (4) step();
    for (int i = 0; i < 4; i++) push(ADR_W'(16'h00A0 + i), 2'd0);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    push(16'h0055, 2'd0);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d want 4", fifo_count); end
    pulse_end(3);
    wait_start(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_pop_start: got timeout want cpu3_start"); end
    checks++; if (cpu3_start_adr !== 16'h00A0) begin errors++; $display("FAIL full_pop_adr: got %h want 00a0", cpu3_start_adr); end
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d want 3", fifo_count); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", req_ready); end
  endtask

  task automatic test_head_of_line();
    bit ok;
    logic [2:0] seen;
    do_reset();
    push(16'h0300, 2'd3);
    push(16'h0200, 2'd2);
    repeat (4) step();
    checks++; if (core_state !== 3'b110) begin errors++; $display("FAIL hol_setup: got %b want 110", core_state); end
    push(16'h0201, 2'd2);
    push(16'h0202, 2'd0);
    seen = 3'b000;
    for (int i = 0; i < 6; i++) begin
      seen |= starts;
      step();
    end
    checks++; if (seen !== 3'b000) begin errors++; $display("FAIL hol_blocked: got %b want 000", seen); end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL hol_count: got %0d want 2", fifo_count); end
    pulse_end(2);
    wait_start(2, ok);
    checks++; if (!ok || cpu2_start_adr !== 16'h0201) begin errors++; $display("FAIL hol_core2: got ok=%b adr=%h want ok=1 adr=0201", ok, cpu2_start_adr); end
    wait_start(1, ok);
    checks++; if (!ok || cpu1_start_adr !== 16'h0202) begin errors++; $display("FAIL hol_core1: got ok=%b adr=%h want ok=1 adr=0202", ok, cpu1_start_adr); end
  endtask

  task automatic test_end_overlap();
    do_reset();
    pulse_end(1);
    checks++; if (core_state !== 3'b000 || fifo_count !== 3'd0 || all_idle !== 1'b1) begin errors++; $display("FAIL spurious_end: got state=%b count=%0d idle=%b want 000 0 1", core_state, fifo_count, all_idle); end
    for (int i = 0; i < 3; i++) push(ADR_W'(16'h0E00 + i), 2'd0);
    repeat (4) step();
    push(16'h0333, 2'd0);
    repeat (2) step();
    checks++; if (starts !== 3'b000 || fifo_count !== 3'd1) begin errors++; $display("FAIL overlap_stall: got starts=%b count=%0d want 000 1", starts, fifo_count); end
    cpu3_end = 1'b1;
    step();
    cpu3_end = 1'b0;
    checks++; if (cpu3_start !== 1'b0 || core_state !== 3'b011) begin errors++; $display("FAIL overlap_not_chosen: got start=%b state=%b want 0 011", cpu3_start, core_state); end
    step();
    checks++; if (cpu3_start !== 1'b1 || cpu3_start_adr !== 16'h0333 || core_state !== 3'b111) begin errors++; $display("FAIL overlap_next: got start=%b adr=%h state=%b want 1 0333 111", cpu3_start, cpu3_start_adr, core_state); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push(16'h0111, 2'd1);
    push(16'h0222, 2'd2);
    for (int i = 0; i < 3; i++) push(ADR_W'(16'h001A + i), 2'd1);
    repeat (2) step();
    checks++; if (core_state !== 3'b011 || fifo_count !== 3'd3) begin errors++; $display("FAIL mid_setup: got state=%b count=%0d want 011 3", core_state, fifo_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (core_state !== 3'b000 || fifo_count !== 3'd0) begin errors++; $display("FAIL mid_reset_state: got state=%b count=%0d want 000 0", core_state, fifo_count); end
    checks++; if (starts !== 3'b000 || all_idle !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_outs: got starts=%b idle=%b ready=%b want 000 1 1", starts, all_idle, req_ready); end
    step();
    rst = 1'b1;
    pulse_end(1);
    checks++; if (core_state !== 3'b000) begin errors++; $display("FAIL mid_late_end: got %b want 000", core_state); end
    push(16'h0777, 2'd0);
    wait_start(1, ok);
    checks++; if (!ok || cpu1_start_adr !== 16'h0777) begin errors++; $display("FAIL mid_restart: got ok=%b adr=%h want ok=1 adr=0777", ok, cpu1_start_adr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_head_of_line();
    test_end_overlap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
